echo_capture: RTL

- Downstream stage of the transmit trigger generator, in the same 50 MHz `clk` domain.
- Consumes the transmit trigger pulse and, after a programmable blanking delay, captures a window of ADC echo samples into an on-chip buffer.
- The host/readout logic drains the buffer through a simple read-strobe interface.
- One capture per arm, so each A-scan is frozen until it is read.

---
 rtl/echo_capture_pkg.sv | 24 ++
 rtl/capture_ram.sv | 26 ++
 rtl/echo_capture.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/echo_capture_pkg.sv
// Shared definitions for the echo capture block: FSM encoding, buffer depth, window length rule.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
// Contents: state_t (IDLE/ARMED/DELAY/CAPTURE/READY), DEPTH_LOG2_DEF/DEPTH_DEF, eff_len().
package echo_capture_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARMED   = 3'd1,
    ST_DELAY   = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_READY   = 3'd4
  } state_t;

  localparam int DEPTH_LOG2_DEF = 10;
  localparam int DEPTH_DEF      = 1 << DEPTH_LOG2_DEF;

  // A requested length of 0, or one larger than the buffer, captures the whole buffer.
  function automatic int unsigned eff_len(input int unsigned req, input int unsigned depth);
    if ((req == 0) || (req > depth)) return depth;
    return req;
  endfunction

endpackage

// File: rtl/capture_ram.sv
// Simple dual-port sample buffer: one write port, one read port, common clock.
// Latency: read data appears on rdata the cycle after re/raddr are presented.
// Backpressure: none; writes and reads are accepted every cycle they are enabled.
// Ports: clk; we/waddr/wdata write port; re/raddr read request; rdata registered read data.
// The array carries no reset; rdata is only meaningful after a read.
module capture_ram #(
  parameter int W  = 8,
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/echo_capture.sv
// Echo capture: after a transmit trigger and a blanking delay, freezes one window of ADC samples for readout.
// Latency: trigger seen 3 edges after trig_in rises; first sample taken 1 cycle after CAPTURE entry; rd_valid 1 cycle after rd_en.
// Backpressure: none; the host paces readout with rd_en, a frozen window waits indefinitely in READY.
// Ports: clk, rst_n (async, active-low); trig_in (async), adc_data; cfg_delay/cfg_len latched at trigger;
//        arm strobe; rd_en -> rd_data/rd_valid/rd_last; busy/done/overrun status; peak_val/peak_idx.
// Build option: define ECHO_PEAK_DETECT_EN to track the window maximum, otherwise the peak outputs read 0.
module echo_capture
  import echo_capture_pkg::*;
#(
  parameter int ADC_W      = 8,
  parameter int DEPTH_LOG2 = 10,
  parameter int DELAY_W    = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  trig_in,
  input  logic [ADC_W-1:0]      adc_data,
  input  logic [DELAY_W-1:0]    cfg_delay,
  input  logic [DEPTH_LOG2:0]   cfg_len,
  input  logic                  arm,
  input  logic                  rd_en,
  output logic [ADC_W-1:0]      rd_data,
  output logic                  rd_valid,
  output logic                  rd_last,
  output logic                  busy,
  output logic                  done,
  output logic                  overrun,
  output logic [ADC_W-1:0]      peak_val,
  output logic [DEPTH_LOG2-1:0] peak_idx
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int PW    = DEPTH_LOG2 + 1;

  state_t             state, state_nxt;
  logic               sync1, sync2, sync3;
  logic               trg_det;
  logic [DELAY_W-1:0] dly_q, dly_cnt;
  logic [PW-1:0]      len_q, len_m1, wr_ptr, rd_ptr;
  logic               rd_valid_q, rd_last_q, overrun_q;
  logic [ADC_W-1:0]   ram_q;
  logic               trg_take, arm_act, cap_last, rd_go, wr_en;

  assign trg_det  = sync2 & ~sync3;
  // A trigger in ARMED beats a coincident arm strobe.
  assign trg_take = (state == ST_ARMED) && trg_det;
  assign arm_act  = arm && !trg_take;
  assign len_m1   = len_q - PW'(1);
  assign cap_last = (wr_ptr == len_m1);
  assign wr_en    = (state == ST_CAPTURE);
  // Reads stop at the window end; an arm in the same cycle discards the buffer, so no read either.
  assign rd_go    = (state == ST_READY) && rd_en && !arm && (rd_ptr < len_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: begin
        if (arm) state_nxt = ST_ARMED;
      end
      ST_ARMED: begin
        if (trg_det)  state_nxt = (cfg_delay == '0) ? ST_CAPTURE : ST_DELAY;
        else if (arm) state_nxt = ST_ARMED;
      end
      ST_DELAY: begin
        if (arm)                    state_nxt = ST_ARMED;
        else if (dly_cnt == dly_q)  state_nxt = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        if (arm)           state_nxt = ST_ARMED;
        else if (cap_last) state_nxt = ST_READY;
      end
      ST_READY: begin
        if (arm)                          state_nxt = ST_ARMED;
        else if (rd_valid_q && rd_last_q) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1      <= 1'b0;
      sync2      <= 1'b0;
      sync3      <= 1'b0;
      dly_q      <= '0;
      dly_cnt    <= '0;
      len_q      <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      sync1 <= trig_in;
      sync2 <= sync1;
      sync3 <= sync2;

      if (trg_take) begin
        dly_q <= cfg_delay;
        len_q <= PW'(eff_len(32'(cfg_len), DEPTH));
      end

      // Preloaded to 1 while armed so DELAY lasts exactly dly_q cycles.
      if (state == ST_DELAY)      dly_cnt <= dly_cnt + DELAY_W'(1);
      else if (state == ST_ARMED) dly_cnt <= DELAY_W'(1);
      else                        dly_cnt <= '0;

      if (state == ST_CAPTURE) wr_ptr <= wr_ptr + PW'(1);
      else                     wr_ptr <= '0;

      if (state != ST_READY) rd_ptr <= '0;
      else if (rd_go)        rd_ptr <= rd_ptr + PW'(1);

      rd_valid_q <= rd_go;
      rd_last_q  <= rd_go && (rd_ptr == len_m1);

      if (arm_act) overrun_q <= 1'b0;
      else if (trg_det && ((state == ST_DELAY) || (state == ST_CAPTURE) || (state == ST_READY)))
        overrun_q <= 1'b1;
    end
  end

  capture_ram #(
    .W  (ADC_W),
    .AW (DEPTH_LOG2)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr[DEPTH_LOG2-1:0]),
    .wdata (adc_data),
    .re    (rd_go),
    .raddr (rd_ptr[DEPTH_LOG2-1:0]),
    .rdata (ram_q)
  );

  // The RAM output register has no reset; masking keeps rd_data at 0 outside valid beats.
  assign rd_data  = rd_valid_q ? ram_q : '0;
  assign rd_valid = rd_valid_q;
  assign rd_last  = rd_last_q;
  assign busy     = (state == ST_ARMED) || (state == ST_DELAY) || (state == ST_CAPTURE);
  assign done     = (state == ST_READY);
  assign overrun  = overrun_q;

`ifdef ECHO_PEAK_DETECT_EN
  logic [ADC_W-1:0]      pk_val;
  logic [DEPTH_LOG2-1:0] pk_idx;

  // Index 0 seeds the tracker; strict greater-than keeps the first occurrence of the max.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pk_val <= '0;
      pk_idx <= '0;
    end else if (state == ST_CAPTURE) begin
      if ((wr_ptr == '0) || (adc_data > pk_val)) begin
        pk_val <= adc_data;
        pk_idx <= wr_ptr[DEPTH_LOG2-1:0];
      end
    end
  end

  assign peak_val = pk_val;
  assign peak_idx = pk_idx;
`else
  assign peak_val = '0;
  assign peak_idx = '0;
`endif

endmodule
